// File: rtl/keypad_time_entry.sv
// -----------------------------------------------------------------------------
// keypad_time_entry
//
// Scans a 4x4 active-low matrix keypad, debounces it over whole scans, and
// turns accepted key presses into a BCD time edit buffer.  A value reaches
// time_bcd only on '#' and only when its fields are in range.
//
// Key map (row r, col c):  r0 = 1 2 3 A   r1 = 4 5 6 B
//                          r2 = 7 8 9 C   r3 = * 0 # D
// Codes: digits 0-9, A-D = 0xA-0xD, '*' = 0xE, '#' = 0xF.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   en         entry enable (level); low clears the edit buffer and parks the scan
//   mode       0 = 4-digit XX:YY in the m/s positions, 1 = hh:mm:ss
//   row[3:0]   keypad rows, active-low, asynchronous to clk
//   col[3:0]   keypad column drive, active-low one-hot (1111 when idle)
//   edit_bcd   live edit buffer {h1,h2,m1,m2,s1,s2}
//   time_bcd   last committed value, same packing
//   entry_cnt  digits entered since the last clear (saturating)
//   key_valid  one-cycle pulse per accepted press
//   key_code   code of the last accepted key
//   commit     one-cycle pulse when time_bcd is updated
//   err        one-cycle pulse when a commit is rejected
// -----------------------------------------------------------------------------
module keypad_time_entry #(
    parameter int CLK_HZ         = 100_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        mode,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [23:0] edit_bcd,
    output logic [23:0] time_bcd,
    output logic [2:0]  entry_cnt,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        commit,
    output logic        err
);

    localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [7:0] DEB_N = 8'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_DEB,
        S_HELD,
        S_RELEASE_DEB
    } state_t;

    // -------------------------------------------------------------------------
    // Row synchronizer (idle rows read high)
    // -------------------------------------------------------------------------
    logic [3:0] row_meta;
    logic [3:0] row_sync;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge value; blocking here would collapse the
    // two-flop chain into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // -------------------------------------------------------------------------
    // Key lookup
    // -------------------------------------------------------------------------
    function automatic logic [3:0] key_lut(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    // Range check for a commit: digits <= 9, tens of minutes/seconds <= 5,
    // and in six-digit mode the hour must not exceed 23.
    function automatic logic fields_ok(input logic [23:0] b, input logic six);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (b[i*4 +: 4] > 4'd9) ok = 1'b0;
        end
        if (b[15:12] > 4'd5) ok = 1'b0;
        if (b[7:4]   > 4'd5) ok = 1'b0;
        if (six && ((b[23:20] > 4'd2) ||
                    ((b[23:20] == 4'd2) && (b[19:16] > 4'd3)))) ok = 1'b0;
        return ok;
    endfunction

    // -------------------------------------------------------------------------
    // Column scan: per-tick sample, whole-scan classification
    // -------------------------------------------------------------------------
    logic [TICK_W-1:0] tick_cnt;
    logic [1:0]        acc_hits;   // keys seen so far this scan: 0, 1, 2 = many
    logic [3:0]        acc_code;
    state_t            state;
    logic [7:0]        deb_cnt;
    logic [3:0]        cand;

    logic [1:0] col_idx;
    logic [3:0] rows_dn;
    logic [1:0] row_idx;
    logic [1:0] col_hits;
    logic [2:0] hit_sum;
    logic [1:0] scan_hits;
    logic [3:0] scan_code;
    logic       tick;
    logic       scan_done;
    logic       scan_one;
    logic       scan_none;
    logic [7:0] deb_next;
    logic       accept;
    logic [3:0] accept_code;

    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        col_idx = 2'd0;
        case (col)
            4'b1110: col_idx = 2'd0;
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase

        rows_dn = ~row_sync;
        row_idx = 2'd0;
        case (rows_dn)
            4'b0010: row_idx = 2'd1;
            4'b0100: row_idx = 2'd2;
            4'b1000: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase

        // Clearing the lowest set bit leaves zero only for a single key.
        if (rows_dn == 4'd0)
            col_hits = 2'd0;
        else if ((rows_dn & 4'(rows_dn - 4'd1)) == 4'd0)
            col_hits = 2'd1;
        else
            col_hits = 2'd2;

        hit_sum   = {1'b0, acc_hits} + {1'b0, col_hits};
        scan_hits = (hit_sum > 3'd2) ? 2'd2 : hit_sum[1:0];
        scan_code = (col_hits == 2'd1) ? key_lut(row_idx, col_idx) : acc_code;

        tick      = en && (col != 4'hF) && (tick_cnt == TICK_LAST);
        scan_done = tick && (col_idx == 2'd3);
        scan_one  = (scan_hits == 2'd1);
        scan_none = (scan_hits == 2'd0);
        deb_next  = deb_cnt + 8'd1;

        // A press is accepted at the end of the scan that completes the
        // debounce count; DEBOUNCE_SCANS = 1 accepts straight from IDLE.
        accept      = 1'b0;
        accept_code = cand;
        if (scan_done && scan_one) begin
            if (state == S_IDLE && DEB_N == 8'd1) begin
                accept      = 1'b1;
                accept_code = scan_code;
            end else if (state == S_PRESS_DEB && scan_code == cand && deb_next == DEB_N) begin
                accept      = 1'b1;
                accept_code = cand;
            end
        end
    end

    // Scan sequencing and debounce FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col      <= 4'hF;
            tick_cnt <= '0;
            acc_hits <= 2'd0;
            acc_code <= 4'h0;
            state    <= S_IDLE;
            deb_cnt  <= 8'd0;
            cand     <= 4'h0;
        end else if (!en) begin
            col      <= 4'hF;
            tick_cnt <= '0;
            acc_hits <= 2'd0;
            acc_code <= 4'h0;
            state    <= S_IDLE;
            deb_cnt  <= 8'd0;
        end else if (col == 4'hF) begin
            // First cycle after enable: start driving column 0.
            col      <= 4'b1110;
            tick_cnt <= '0;
            acc_hits <= 2'd0;
            acc_code <= 4'h0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                col <= {col[2:0], col[3]};
                if (scan_done) begin
                    acc_hits <= 2'd0;
                    acc_code <= 4'h0;
                end else begin
                    acc_hits <= scan_hits;
                    acc_code <= scan_code;
                end
            end

            if (scan_done) begin
                case (state)
                    S_IDLE: begin
                        if (scan_one) begin
                            cand    <= scan_code;
                            deb_cnt <= 8'd1;
                            state   <= (DEB_N == 8'd1) ? S_HELD : S_PRESS_DEB;
                        end
                    end
                    S_PRESS_DEB: begin
                        if (scan_one && scan_code == cand) begin
                            deb_cnt <= deb_next;
                            if (deb_next == DEB_N) state <= S_HELD;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_HELD: begin
                        // Any key activity, even several keys, keeps the press held.
                        if (scan_none) begin
                            deb_cnt <= 8'd1;
                            state   <= (DEB_N == 8'd1) ? S_IDLE : S_RELEASE_DEB;
                        end
                    end
                    S_RELEASE_DEB: begin
                        if (scan_none) begin
                            deb_cnt <= deb_next;
                            if (deb_next == DEB_N) state <= S_IDLE;
                        end else begin
                            state <= S_HELD;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Entry buffer
    // -------------------------------------------------------------------------
    logic [23:0] edit_norm;
    logic [2:0]  cnt_norm;
    logic [2:0]  cnt_max;
    logic [23:0] edit_nx;
    logic [23:0] time_nx;
    logic [2:0]  cnt_nx;
    logic        commit_nx;
    logic        err_nx;

    always_comb begin
        // In four-digit mode the hour digits are held at zero and the count
        // clamped, which also covers a mode switch in the middle of an entry.
        edit_norm = mode ? edit_bcd : {8'h00, edit_bcd[15:0]};
        cnt_norm  = (!mode && entry_cnt > 3'd4) ? 3'd4 : entry_cnt;
        cnt_max   = mode ? 3'd6 : 3'd4;

        edit_nx   = edit_norm;
        cnt_nx    = cnt_norm;
        time_nx   = time_bcd;
        commit_nx = 1'b0;
        err_nx    = 1'b0;

        if (accept) begin
            case (accept_code)
                4'hA: begin
                    edit_nx = mode ? {4'h0, edit_norm[23:4]} : {12'h000, edit_norm[15:4]};
                    cnt_nx  = (cnt_norm == 3'd0) ? 3'd0 : cnt_norm - 3'd1;
                end
                4'hE: begin
                    edit_nx = 24'h0;
                    cnt_nx  = 3'd0;
                end
                4'hF: begin
                    if (fields_ok(edit_norm, mode)) begin
                        time_nx   = edit_norm;
                        commit_nx = 1'b1;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
                4'hB, 4'hC, 4'hD: begin
                end
                default: begin
                    edit_nx = mode ? {edit_norm[19:0], accept_code}
                                   : {8'h00, edit_norm[11:0], accept_code};
                    cnt_nx  = (cnt_norm >= cnt_max) ? cnt_max : cnt_norm + 3'd1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edit_bcd  <= 24'h0;
            time_bcd  <= 24'h0;
            entry_cnt <= 3'd0;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            commit    <= 1'b0;
            err       <= 1'b0;
        end else if (!en) begin
            // Disabled: drop the edit, keep the committed value and last key.
            edit_bcd  <= 24'h0;
            entry_cnt <= 3'd0;
            key_valid <= 1'b0;
            commit    <= 1'b0;
            err       <= 1'b0;
        end else begin
            edit_bcd  <= edit_nx;
            time_bcd  <= time_nx;
            entry_cnt <= cnt_nx;
            key_valid <= accept;
            commit    <= commit_nx;
            err       <= err_nx;
            if (accept) key_code <= accept_code;
        end
    end

endmodule

// File: tb/tb_keypad_time_entry.sv
// -----------------------------------------------------------------------------
// tb_keypad_time_entry
//
// Keypad model pulls a row low while its key is pressed and its column is
// driven low.  Directed table of key presses with hand-derived results, a
// mode-change sequence, randomized key sequences against a digit-array model,
// then bounce, two-key, enable-drop and mid-scan reset corner cases.
// -----------------------------------------------------------------------------
module tb_keypad_time_entry;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        mode;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [23:0] edit_bcd;
    logic [23:0] time_bcd;
    logic [2:0]  entry_cnt;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        commit;
    logic        err;

    keypad_time_entry #(
        .CLK_HZ        (400),
        .SCAN_HZ       (100),
        .DEBOUNCE_SCANS(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .row      (row),
        .col      (col),
        .edit_bcd (edit_bcd),
        .time_bcd (time_bcd),
        .entry_cnt(entry_cnt),
        .key_valid(key_valid),
        .key_code (key_code),
        .commit   (commit),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Keypad: bit r*4+c is the key at row r, column c.
    logic [15:0] pressed = '0;
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4 + c] && !col[c]) row[r] = 1'b0;
    end

    function automatic int pos_of(input logic [3:0] code);
        case (code)
            4'h1: return 0;  4'h2: return 1;  4'h3: return 2;  4'hA: return 3;
            4'h4: return 4;  4'h5: return 5;  4'h6: return 6;  4'hB: return 7;
            4'h7: return 8;  4'h8: return 9;  4'h9: return 10; 4'hC: return 11;
            4'hE: return 12; 4'h0: return 13; 4'hF: return 14; default: return 15;
        endcase
    endfunction

    // Pulse counters
    int kv_cnt = 0;
    int commit_cnt = 0;
    int err_cnt = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (key_valid) kv_cnt++;
            if (commit)    commit_cnt++;
            if (err)       err_cnt++;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Outputs captured in the key_valid cycle
    logic [3:0]  cap_code;
    logic [23:0] cap_edit;
    logic [23:0] cap_time;
    logic [2:0]  cap_cnt;
    logic        cap_commit;
    logic        cap_err;

    task automatic wait_kv(input int kv0, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (key_valid) begin
                ok         = 1'b1;
                cap_code   = key_code;
                cap_edit   = edit_bcd;
                cap_time   = time_bcd;
                cap_cnt    = entry_cnt;
                cap_commit = commit;
                cap_err    = err;
            end
        end
        check("key_valid within budget", {31'd0, ok}, 32'd1);
    endtask

    task automatic press_key(input logic [3:0] code, input int extra_hold);
        int   kv0;
        logic ok;
        kv0 = kv_cnt;
        pressed[pos_of(code)] = 1'b1;
        wait_kv(kv0, ok);
        repeat (extra_hold) @(negedge clk);
        pressed = '0;
        repeat (100) @(negedge clk);
        check("one key_valid per press", kv_cnt - kv0, 32'd1);
    endtask

    // Behavioural model: six decimal digits h1..s2 as integers.
    int          m_dig[6];
    int          m_cnt;
    logic [23:0] m_time;
    logic        m_commit;
    logic        m_err;

    function automatic logic [23:0] m_pack();
        logic [23:0] v;
        v = 24'h0;
        for (int i = 0; i < 6; i++) v = {v[19:0], 4'(m_dig[i])};
        return v;
    endfunction

    task automatic model_mode(input logic md);
        if (!md) begin
            m_dig[0] = 0;
            m_dig[1] = 0;
            if (m_cnt > 4) m_cnt = 4;
        end
    endtask

    task automatic model_key(input logic md, input logic [3:0] k);
        int n, lo, hh, mm, ss;
        n  = md ? 6 : 4;
        lo = 6 - n;
        m_commit = 1'b0;
        m_err    = 1'b0;
        model_mode(md);
        if (k <= 4'd9) begin
            for (int i = lo; i < 5; i++) m_dig[i] = m_dig[i+1];
            m_dig[5] = int'(k);
            if (m_cnt < n) m_cnt++;
        end else if (k == 4'hA) begin
            for (int i = 5; i > lo; i--) m_dig[i] = m_dig[i-1];
            m_dig[lo] = 0;
            if (m_cnt > 0) m_cnt--;
        end else if (k == 4'hE) begin
            for (int i = 0; i < 6; i++) m_dig[i] = 0;
            m_cnt = 0;
        end else if (k == 4'hF) begin
            hh = m_dig[0] * 10 + m_dig[1];
            mm = m_dig[2] * 10 + m_dig[3];
            ss = m_dig[4] * 10 + m_dig[5];
            if (mm < 60 && ss < 60 && (!md || hh < 24)) begin
                m_time   = m_pack();
                m_commit = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    typedef struct {
        logic        mode;
        logic [3:0]  key;
        logic [23:0] edit;
        logic [2:0]  cnt;
        logic        commit;
        logic        err;
        logic [23:0] tm;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic md, input logic [3:0] k, input logic [23:0] e,
                       input logic [2:0] c, input logic cm, input logic er,
                       input logic [23:0] t);
        vec_t v;
        v.mode = md; v.key = k; v.edit = e; v.cnt = c; v.commit = cm; v.err = er; v.tm = t;
        tbl.push_back(v);
    endtask

    logic [3:0] exp_cols[4];

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          kv0;
        logic        ok;
        logic [3:0]  k;
        int          r;
        logic [23:0] t_keep;

        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("reset col",       {28'd0, col}, 32'hF);
        check("reset edit",      {8'd0, edit_bcd}, 32'h0);
        check("reset time",      {8'd0, time_bcd}, 32'h0);
        check("reset entry_cnt", {29'd0, entry_cnt}, 32'h0);
        check("reset key_code",  {28'd0, key_code}, 32'h0);
        check("reset pulses",    {29'd0, key_valid, commit, err}, 32'h0);

        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("disabled col", {28'd0, col}, 32'hF);

        // Column walk, 4 cycles per step, first step the cycle after en rises
        exp_cols[0] = 4'hE; exp_cols[1] = 4'hD; exp_cols[2] = 4'hB; exp_cols[3] = 4'h7;
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("col step %0d", i), {28'd0, col}, {28'd0, exp_cols[(i / 4) % 4]});
        end
        check("no pulses while idle", kv_cnt + commit_cnt + err_cnt, 32'd0);

        // Directed table
        add(1, 4'h1, 24'h000001, 1, 0, 0, 24'h000000);
        add(1, 4'h2, 24'h000012, 2, 0, 0, 24'h000000);
        add(1, 4'h3, 24'h000123, 3, 0, 0, 24'h000000);
        add(1, 4'h4, 24'h001234, 4, 0, 0, 24'h000000);
        add(1, 4'h5, 24'h012345, 5, 0, 0, 24'h000000);
        add(1, 4'h6, 24'h123456, 6, 0, 0, 24'h000000);
        add(1, 4'hF, 24'h123456, 6, 1, 0, 24'h123456);
        add(1, 4'h2, 24'h234562, 6, 0, 0, 24'h123456);
        add(1, 4'h5, 24'h345625, 6, 0, 0, 24'h123456);
        add(1, 4'h0, 24'h456250, 6, 0, 0, 24'h123456);
        add(1, 4'h0, 24'h562500, 6, 0, 0, 24'h123456);
        add(1, 4'h0, 24'h625000, 6, 0, 0, 24'h123456);
        add(1, 4'h0, 24'h250000, 6, 0, 0, 24'h123456);
        add(1, 4'hF, 24'h250000, 6, 0, 1, 24'h123456);
        add(1, 4'hE, 24'h000000, 0, 0, 0, 24'h123456);
        add(0, 4'h0, 24'h000000, 1, 0, 0, 24'h123456);
        add(0, 4'h7, 24'h000007, 2, 0, 0, 24'h123456);
        add(0, 4'h3, 24'h000073, 3, 0, 0, 24'h123456);
        add(0, 4'h0, 24'h000730, 4, 0, 0, 24'h123456);
        add(0, 4'hA, 24'h000073, 3, 0, 0, 24'h123456);
        add(0, 4'h9, 24'h000739, 4, 0, 0, 24'h123456);
        add(0, 4'hF, 24'h000739, 4, 1, 0, 24'h000739);
        add(0, 4'hE, 24'h000000, 0, 0, 0, 24'h000739);
        add(0, 4'hA, 24'h000000, 0, 0, 0, 24'h000739);
        add(0, 4'h5, 24'h000005, 1, 0, 0, 24'h000739);
        add(0, 4'h9, 24'h000059, 2, 0, 0, 24'h000739);
        add(0, 4'h5, 24'h000595, 3, 0, 0, 24'h000739);
        add(0, 4'h9, 24'h005959, 4, 0, 0, 24'h000739);
        add(0, 4'hF, 24'h005959, 4, 1, 0, 24'h005959);
        add(0, 4'h6, 24'h009596, 4, 0, 0, 24'h005959);
        add(0, 4'hF, 24'h009596, 4, 0, 1, 24'h005959);
        add(1, 4'hE, 24'h000000, 0, 0, 0, 24'h005959);
        add(1, 4'h2, 24'h000002, 1, 0, 0, 24'h005959);
        add(1, 4'h3, 24'h000023, 2, 0, 0, 24'h005959);
        add(1, 4'h5, 24'h000235, 3, 0, 0, 24'h005959);
        add(1, 4'h9, 24'h002359, 4, 0, 0, 24'h005959);
        add(1, 4'h5, 24'h023595, 5, 0, 0, 24'h005959);
        add(1, 4'h9, 24'h235959, 6, 0, 0, 24'h005959);
        add(1, 4'hF, 24'h235959, 6, 1, 0, 24'h235959);
        add(1, 4'hD, 24'h235959, 6, 0, 0, 24'h235959);
        add(1, 4'hA, 24'h023595, 5, 0, 0, 24'h235959);

        foreach (tbl[i]) begin
            mode = tbl[i].mode;
            repeat (2) @(negedge clk);
            press_key(tbl[i].key, int'($urandom_range(0, 30)));
            check($sformatf("row%0d key_code", i), {28'd0, cap_code}, {28'd0, tbl[i].key});
            check($sformatf("row%0d edit", i), {8'd0, cap_edit}, {8'd0, tbl[i].edit});
            check($sformatf("row%0d entry_cnt", i), {29'd0, cap_cnt}, {29'd0, tbl[i].cnt});
            check($sformatf("row%0d commit/err", i), {30'd0, cap_commit, cap_err},
                  {30'd0, tbl[i].commit, tbl[i].err});
            check($sformatf("row%0d time", i), {8'd0, cap_time}, {8'd0, tbl[i].tm});
        end

        // Mode change mid-entry: hours zeroed and count clamped while mode = 0
        press_key(4'h1, 0);
        check("pre-switch edit", {8'd0, cap_edit}, 32'h235951);
        mode = 1'b0;
        repeat (3) @(negedge clk);
        check("mode0 edit", {8'd0, edit_bcd}, 32'h005951);
        check("mode0 cnt",  {29'd0, entry_cnt}, 32'd4);
        mode = 1'b1;
        repeat (3) @(negedge clk);
        check("back to mode1 edit", {8'd0, edit_bcd}, 32'h005951);
        check("back to mode1 cnt",  {29'd0, entry_cnt}, 32'd4);

        // Randomized key sequences against the model
        m_dig[0] = 0; m_dig[1] = 0; m_dig[2] = 5; m_dig[3] = 9; m_dig[4] = 5; m_dig[5] = 1;
        m_cnt  = 4;
        m_time = 24'h235959;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                mode = ~mode;
                model_mode(mode);
            end
            repeat ($urandom_range(1, 20)) @(negedge clk);
            r = int'($urandom_range(0, 15));
            if (r < 10)       k = 4'($urandom_range(0, 9));
            else if (r < 12)  k = 4'hA;
            else if (r < 14)  k = 4'hF;
            else if (r == 14) k = 4'hE;
            else              k = 4'($urandom_range(11, 13));
            press_key(k, int'($urandom_range(0, 60)));
            model_key(mode, k);
            check($sformatf("rnd%0d key_code", n), {28'd0, cap_code}, {28'd0, k});
            check($sformatf("rnd%0d edit", n), {8'd0, cap_edit}, {8'd0, m_pack()});
            check($sformatf("rnd%0d entry_cnt", n), {29'd0, cap_cnt}, 32'(m_cnt));
            check($sformatf("rnd%0d commit/err", n), {30'd0, cap_commit, cap_err},
                  {30'd0, m_commit, m_err});
            check($sformatf("rnd%0d time", n), {8'd0, cap_time}, {8'd0, m_time});
        end

        // Bounce on key 5, then held: exactly one accepted press
        kv0 = kv_cnt;
        for (int i = 0; i < 8; i++) begin
            pressed[pos_of(4'h5)] = ~pressed[pos_of(4'h5)];
            repeat (5) @(negedge clk);
        end
        pressed[pos_of(4'h5)] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (kv_cnt > kv0) ok = 1'b1;
        end
        check("bounce accepted within budget", {31'd0, ok}, 32'd1);
        repeat (50) @(negedge clk);
        pressed = '0;
        repeat (100) @(negedge clk);
        check("bounce single key_valid", kv_cnt - kv0, 32'd1);
        check("bounce key_code", {28'd0, key_code}, 32'h5);
        model_key(mode, 4'h5);
        check("bounce edit", {8'd0, edit_bcd}, {8'd0, m_pack()});

        // Two keys together never qualify
        kv0 = kv_cnt;
        pressed[pos_of(4'h5)] = 1'b1;
        pressed[pos_of(4'h6)] = 1'b1;
        repeat (150) @(negedge clk);
        pressed = '0;
        repeat (100) @(negedge clk);
        check("two keys no key_valid", kv_cnt - kv0, 32'd0);

        // Enable dropped during debounce
        t_keep = time_bcd;
        kv0 = kv_cnt;
        pressed[pos_of(4'h8)] = 1'b1;
        repeat (20) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("en low col",  {28'd0, col}, 32'hF);
        check("en low edit", {8'd0, edit_bcd}, 32'h0);
        check("en low cnt",  {29'd0, entry_cnt}, 32'd0);
        check("en low time", {8'd0, time_bcd}, {8'd0, m_time});
        repeat (30) @(negedge clk);
        pressed = '0;
        repeat (10) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        check("en rise col", {28'd0, col}, 32'hE);
        repeat (150) @(negedge clk);
        check("en drop no key_valid", kv_cnt - kv0, 32'd0);
        check("en drop time kept", {8'd0, time_bcd}, {8'd0, t_keep});

        // Reset mid-scan / mid-debounce
        kv0 = kv_cnt;
        pressed[pos_of(4'h9)] = 1'b1;
        repeat (25) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid reset col",      {28'd0, col}, 32'hF);
        check("mid reset edit",     {8'd0, edit_bcd}, 32'h0);
        check("mid reset time",     {8'd0, time_bcd}, 32'h0);
        check("mid reset key_code", {28'd0, key_code}, 32'h0);
        check("mid reset kv",       {31'd0, key_valid}, 32'd0);
        repeat (5) @(negedge clk);
        pressed = '0;
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        check("reset no key_valid", kv_cnt - kv0, 32'd0);
        check("after reset time",   {8'd0, time_bcd}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
